// File: rtl/mux_arb.sv
// N-channel valid/ready multiplexer with fixed-select or round-robin arbitration
// feeding a single registered output beat.
module mux_arb #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_chan,
   output logic            out_valid,
   input  logic            out_ready
);

   localparam logic [SW:0] N_L = (SW+1)'(N);

   logic [SW-1:0] ptr;
   logic          accept;
   logic          grant_valid;
   logic [SW-1:0] grant_idx;
   logic [SW:0]   scan;
   logic [SW-1:0] scan_idx;
   logic [W-1:0]  grant_data;

   assign accept = !out_valid || out_ready;

   // Mode 0 only matches channel indices below N, so an out-of-range sel never grants.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      scan_idx    = '0;
      if (!mode) begin
         for (int k = 0; k < N; k++) begin
            if (!grant_valid && sel == SW'(k) && in_valid[k]) begin
               grant_valid = 1'b1;
               grant_idx   = SW'(k);
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            scan = {1'b0, ptr} + (SW+1)'(i);
            if (scan >= N_L) scan = scan - N_L;
            scan_idx = scan[SW-1:0];
            if (!grant_valid && in_valid[scan_idx]) begin
               grant_valid = 1'b1;
               grant_idx   = scan_idx;
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < N; k++) begin
         if (grant_idx == SW'(k)) grant_data = in_data[k*W +: W];
      end
   end

   assign in_ready = (!rst && accept && grant_valid) ? (N'(1) << grant_idx) : '0;

   // A transfer overwrites the held beat directly, so drain and fill share one edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr       <= '0;
      end else if (accept && grant_valid) begin
         out_valid <= 1'b1;
         out_data  <= grant_data;
         out_chan  <= grant_idx;
         if (mode) ptr <= (grant_idx == SW'(N-1)) ? '0 : grant_idx + 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb: a reference model predicts grants, queues the
// expected beats and compares them when they appear on the output.
module tb_mux_arb;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;

   logic            clk;
   logic            rst;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic            mode;
   logic [SW-1:0]   sel;
   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_chan;
   logic            out_valid;
   logic            out_ready;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] chan;
   } beat_t;

   beat_t         exp_q[$];
   int            assert_count = 0;
   int            fail_count   = 0;
   logic          m_valid;
   logic [W-1:0]  m_data;
   logic [SW-1:0] m_chan;
   int            m_ptr;

   mux_arb #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assert_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference arbiter: -1 means no grant.
   function automatic int modelGrant(input logic md, input int s, input logic [N-1:0] v, input int p);
      if (!md) return (s < N && v[s]) ? s : -1;
      for (int i = 0; i < N; i++) begin
         int c;
         c = (p + i) % N;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   // One full cycle: drive after the falling edge, check in_ready, then check outputs after the rising edge.
   task automatic applyStimulus(input logic r, input logic md, input logic [SW-1:0] s,
                                input logic [N-1:0] v, input logic rdy, input logic [N*W-1:0] d);
      int         g;
      logic       acc;
      logic [N-1:0] exp_ready;
      beat_t      b;
      rst = r; mode = md; sel = s; in_valid = v; out_ready = rdy; in_data = d;
      #1;
      acc = !m_valid || rdy;
      g   = modelGrant(md, int'(s), v, m_ptr);
      exp_ready = (!r && acc && g >= 0) ? N'(1 << g) : '0;
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      if (exp_ready != '0) begin
         b.data = d[g*W +: W];
         b.chan = SW'(g);
         exp_q.push_back(b);
      end
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = 0;
         exp_q.delete();
      end else if (exp_ready != '0) begin
         m_valid = 1'b1;
         if (md) m_ptr = (g + 1) % N;
      end else if (rdy) begin
         m_valid = 1'b0;
      end
      #1;
      checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
      if (!r && exp_ready != '0) begin
         if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'(1), 32'(0));
         end else begin
            b = exp_q.pop_front();
            m_data = b.data;
            m_chan = b.chan;
            checkOutput("out_data", 32'(out_data), 32'(m_data));
            checkOutput("out_chan", 32'(out_chan), 32'(m_chan));
         end
      end else if (m_valid || r) begin
         checkOutput("held_data", 32'(out_data), 32'(m_data));
         checkOutput("held_chan", 32'(out_chan), 32'(m_chan));
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
      m_valid = 1'b0; m_data = '0; m_chan = '0; m_ptr = 0;
      @(negedge clk);

      // Reset with every channel offering data
      applyStimulus(1'b1, 1'b0, 2'd0, 4'hF, 1'b1, 32'hDEADBEEF);
      applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b1, 32'h01234567);
      checkOutput("reset_out_data", 32'(out_data), 32'h0);

      // Fixed select of channel 2
      applyStimulus(1'b0, 1'b0, 2'd2, 4'b0100, 1'b1, {8'h44, 8'hA5, 8'h22, 8'h11});
      checkOutput("fixed_sel2_data", 32'(out_data), 32'hA5);
      checkOutput("fixed_sel2_chan", 32'(out_chan), 32'd2);

      // Selected channel idle: no grant, held beat drains
      applyStimulus(1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, 32'h55667788);
      applyStimulus(1'b0, 1'b0, 2'd1, 4'b1101, 1'b1, 32'h99AABBCC);
      checkOutput("fixed_idle_valid", 32'(out_valid), 32'd0);

      // Mode/sel changes while a beat is stalled must not disturb it
      applyStimulus(1'b0, 1'b0, 2'd3, 4'b1000, 1'b1, {8'h3C, 8'h00, 8'h00, 8'h00});
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, {8'h00, 8'h00, 8'h00, 8'h7E});
      applyStimulus(1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, {8'h00, 8'h00, 8'h00, 8'h7E});
      checkOutput("stall_keeps_chan", 32'(out_chan), 32'd3);
      applyStimulus(1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, {8'h00, 8'h00, 8'h00, 8'h7E});
      checkOutput("stall_release_data", 32'(out_data), 32'h7E);

      // Round-robin with every channel valid, back-to-back beats
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
         checkOutput("rr_sequence_chan", 32'(out_chan), 32'(i % N));
      end

      // Back-pressure for three cycles, then channel 1 is taken
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 1'b1, 2'd0, 4'b0010, 1'b0, $urandom);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0010, 1'b1, {8'h00, 8'h00, 8'hC3, 8'h00});
      checkOutput("backpressure_data", 32'(out_data), 32'hC3);

      // Pointer at 3 wraps to channel 0, then moves to channel 1
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0100, 1'b1, $urandom);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, $urandom);
      checkOutput("wrap_chan0", 32'(out_chan), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0011, 1'b1, $urandom);
      checkOutput("wrap_chan1", 32'(out_chan), 32'd1);

      // Reset discards a held beat; round-robin restarts at channel 0
      applyStimulus(1'b0, 1'b1, 2'd0, 4'b0100, 1'b0, $urandom);
      applyStimulus(1'b1, 1'b1, 2'd0, 4'hF, 1'b0, $urandom);
      checkOutput("midreset_valid", 32'(out_valid), 32'd0);
      checkOutput("midreset_chan", 32'(out_chan), 32'd0);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'hF, 1'b1, $urandom);
      checkOutput("post_reset_chan", 32'(out_chan), 32'd0);

      // Random traffic
      for (int i = 0; i < 80; i++) begin
         applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom), 2'($urandom),
                       4'($urandom), ($urandom_range(0, 3) != 0), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/mux_arb.md
MUX_ARB -- requirements
Module: mux_arb

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning number of input channels (2..16).
REQ-002 The block SHALL have parameter W, default 8, meaning data width per channel.
REQ-003 The block SHALL derive SW = max(1, clog2(N)) as the channel-index width; it SHALL NOT be a user parameter.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 The block SHALL have port in_data, input, N*W, where channel k occupies bits [k*W+W-1 : k*W].
REQ-007 The block SHALL have port in_valid, input, N, where bit k means channel k offers a beat.
REQ-008 The block SHALL have port in_ready, output, N, where bit k means channel k's beat is taken this cycle.
REQ-009 The block SHALL have port mode, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SW, the channel index used when mode = 0.
REQ-011 The block SHALL have port out_data, output, W, the registered selected data.
REQ-012 The block SHALL have port out_chan, output, SW, the index of the channel that sourced out_data.
REQ-013 The block SHALL have port out_valid, output, 1, meaning out_data/out_chan hold a beat.
REQ-014 The block SHALL have port out_ready, input, 1, the downstream accept.

Function
REQ-015 The block SHALL hold one output beat in a register; accept = !out_valid || out_ready.
REQ-016 In mode 0, grant SHALL be sel when sel < N and in_valid[sel] = 1; otherwise there SHALL be no grant (sel >= N: never grant).
REQ-017 In mode 1, grant SHALL be the first channel with in_valid = 1 scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (wrap-around); with no valid channel there SHALL be no grant.
REQ-018 in_ready SHALL be one-hot or zero: in_ready[k] = accept && grant exists && grant == k, combinational in the same cycle.
REQ-019 A transfer SHALL occur when in_valid[k] && in_ready[k]; on that edge out_data <= channel k data, out_chan <= k, out_valid <= 1 (latency one cycle).
REQ-020 With no transfer and out_ready = 1, out_valid SHALL go to 0; with out_ready = 0, out_valid/out_data/out_chan SHALL hold unchanged.
REQ-021 Simultaneous drain and fill (out_valid && out_ready && transfer) SHALL replace the beat with no bubble, sustaining one beat per cycle.
REQ-022 The round-robin pointer ptr (SW bits, range 0..N-1) SHALL update to (grant+1) mod N on each mode-1 transfer and SHALL hold otherwise, including in all mode-0 cycles.
REQ-023 mode and sel SHALL be sampled every cycle; a change SHALL affect the grant in the same cycle and SHALL NOT disturb a held output beat.
REQ-024 Data on non-granted channels SHALL never reach out_data; in_data values SHALL pass unmodified (no width change, no arithmetic).

Reset
REQ-025 While rst = 1 at a rising edge, out_valid SHALL become 0, out_data 0, out_chan 0, ptr 0.
REQ-026 While rst = 1, in_ready SHALL be all zero, so no transfer occurs.
REQ-027 Reset mid-operation SHALL discard any held output beat; no beat is replayed after reset.

Verification
REQ-028 Mode 0, sel=2, in_valid=4'b0100, ch2 data 8'hA5, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=8'hA5, out_chan=2.
REQ-029 Mode 0, sel=1, in_valid=4'b1101 -> in_ready=0 and out_valid falls to 0 after any held beat drains.
REQ-030 Mode 1, all four channels valid continuously, out_ready=1 -> out_chan sequence 0,1,2,3,0,1 over six consecutive cycles, out_valid held 1.
REQ-031 Mode 1, out_valid=1, out_ready=0 for 3 cycles with in_valid=4'b0010 -> in_ready=0, out_data unchanged; on out_ready=1 ch1 taken same cycle, new beat next cycle.
REQ-032 Mode 1, ptr=3, in_valid=4'b0011 -> grant ch0 (wrap-around), then ptr=1, next grant ch1.
REQ-033 Beat held (out_valid=1), rst=1 for one cycle with all in_valid=1 -> out_valid=0, out_chan=0, in_ready=0 during reset; first grant after reset is ch0 in mode 1.
